// File: rtl/comm_buffer_writer_if.sv
// -----------------------------------------------------------------------------
// comm_buffer_writer_if
//
// Purpose:
//   Bundles the control, input-stream, Avalon-MM write master and status
//   signals of comm_buffer_writer into one interface. Clock and reset stay
//   plain ports on the module.
//
// Signal summary:
//   ctrl_start_i / ctrl_abort_i      one-cycle command pulses
//   ctrl_base_addr_i / ctrl_length_i transfer base word address and length
//   stream_data_i / stream_be_i      input word and its byteenable
//   stream_valid_i / stream_ready_o  input stream handshake
//   avm_address_o .. avm_byteenable_o  Avalon write request towards the slave
//   avm_waitrequest_i                Avalon slave stall
//   status_busy_o / status_done_o    transfer in progress / end-of-transfer pulse
//   status_words_o                   words accepted by the slave
//   status_error_o                   sticky "start while busy" flag
//
// Modports:
//   master : the writer block itself
//   slave  : the surrounding system (command source, stream source, slave)
// -----------------------------------------------------------------------------
interface comm_buffer_writer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 13
);
    logic                      ctrl_start_i;
    logic                      ctrl_abort_i;
    logic [ADDR_WIDTH-1:0]     ctrl_base_addr_i;
    logic [LEN_WIDTH-1:0]      ctrl_length_i;

    logic [DATA_WIDTH-1:0]     stream_data_i;
    logic [DATA_WIDTH/8-1:0]   stream_be_i;
    logic                      stream_valid_i;
    logic                      stream_ready_o;

    logic [ADDR_WIDTH-1:0]     avm_address_o;
    logic                      avm_write_o;
    logic [DATA_WIDTH-1:0]     avm_writedata_o;
    logic [DATA_WIDTH/8-1:0]   avm_byteenable_o;
    logic                      avm_waitrequest_i;

    logic                      status_busy_o;
    logic                      status_done_o;
    logic [LEN_WIDTH-1:0]      status_words_o;
    logic                      status_error_o;

    modport master (
        input  ctrl_start_i, ctrl_abort_i, ctrl_base_addr_i, ctrl_length_i,
        input  stream_data_i, stream_be_i, stream_valid_i,
        output stream_ready_o,
        output avm_address_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
        input  avm_waitrequest_i,
        output status_busy_o, status_done_o, status_words_o, status_error_o
    );

    modport slave (
        output ctrl_start_i, ctrl_abort_i, ctrl_base_addr_i, ctrl_length_i,
        output stream_data_i, stream_be_i, stream_valid_i,
        input  stream_ready_o,
        input  avm_address_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
        output avm_waitrequest_i,
        input  status_busy_o, status_done_o, status_words_o, status_error_o
    );
endinterface

// File: rtl/comm_buffer_writer.sv
// -----------------------------------------------------------------------------
// comm_buffer_writer
//
// Purpose:
//   Avalon-MM write master that fills the 64-bit data buffer of the
//   communication module. A start pulse latches a base word address and a
//   length; words then arrive on a valid/ready stream, pass through a small
//   FIFO and are written one per Avalon write at base, base+1, ... wrapping
//   modulo 2^ADDR_WIDTH. An abort finishes any write already on the bus and
//   discards everything still buffered.
//
// Ports:
//   clock_sink_clk    single clock
//   reset_sink_reset  asynchronous, active-high reset
//   bus               comm_buffer_writer_if.master (control, stream,
//                     Avalon master and status signals)
//
// All outputs are registered. stream_ready_o is computed one cycle ahead from
// the next-state values, so it is exactly "FIFO not full, words_in < length,
// not aborting, running" for the current cycle.
// -----------------------------------------------------------------------------
module comm_buffer_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 13,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clock_sink_clk,
    input  logic                 reset_sink_reset,
    comm_buffer_writer_if.master bus
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FIFO_FULL = CNT_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                 state_r,        state_next_s;
    logic [ADDR_WIDTH-1:0]  base_r,         base_next_s;
    logic [LEN_WIDTH-1:0]   length_r,       length_next_s;
    logic [LEN_WIDTH-1:0]   words_done_r,   words_done_next_s;
    logic [LEN_WIDTH-1:0]   words_in_r,     words_in_next_s;
    logic                   abort_pend_r,   abort_pend_next_s;

    logic [DATA_WIDTH-1:0]  fifo_data_r [FIFO_DEPTH];
    logic [BE_WIDTH-1:0]    fifo_be_r   [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r,       wr_ptr_next_s;
    logic [PTR_WIDTH-1:0]   rd_ptr_r,       rd_ptr_next_s;
    logic [CNT_WIDTH-1:0]   count_r,        count_next_s;

    logic                   write_r,        write_next_s;
    logic [ADDR_WIDTH-1:0]  address_r,      address_next_s;
    logic [DATA_WIDTH-1:0]  writedata_r,    writedata_next_s;
    logic [BE_WIDTH-1:0]    byteenable_r,   byteenable_next_s;

    logic                   ready_r,        ready_next_s;
    logic                   busy_r,         busy_next_s;
    logic                   done_r,         done_next_s;
    logic                   error_r,        error_next_s;

    // ---------------------------------------------------------------- events
    logic                   start_ok_s;
    logic                   push_s;
    logic                   accept_s;
    logic                   abort_now_s;
    logic                   stop_s;
    logic                   last_s;
    logic                   slot_free_s;
    logic                   finish_s;
    logic                   flush_s;
    logic                   issue_s;
    logic [CNT_WIDTH-1:0]   avail_s;
    logic [PTR_WIDTH-1:0]   head_ptr_s;
    logic [DATA_WIDTH-1:0]  head_data_s;
    logic [BE_WIDTH-1:0]    head_be_s;

    // Event decode: handshakes, abort/finish conditions and the next FIFO head.
    always_comb begin
        // A start is honoured whenever no transfer is running; DONE lasts a
        // single cycle and is already "not busy", so it accepts a start too.
        start_ok_s  = bus.ctrl_start_i && (state_r != ST_RUN);
        push_s      = ready_r && bus.stream_valid_i;
        accept_s    = write_r && !bus.avm_waitrequest_i;
        abort_now_s = (state_r == ST_RUN) && bus.ctrl_abort_i;
        stop_s      = abort_now_s || abort_pend_r;
        last_s      = accept_s && ((words_done_r + LEN_WIDTH'(1'b1)) == length_r);
        // The Avalon request register is free for a new word this cycle.
        slot_free_s = !write_r || accept_s;
        // Normal end on the last accept; abort end once no write is pending.
        finish_s    = (state_r == ST_RUN) && (last_s || (stop_s && slot_free_s));
        flush_s     = start_ok_s || finish_s;
        avail_s     = count_r + CNT_WIDTH'(push_s) - CNT_WIDTH'(accept_s);
        issue_s     = (state_r == ST_RUN) && !finish_s && !stop_s && slot_free_s &&
                      (avail_s != {CNT_WIDTH{1'b0}});

        // Head after this cycle's pop. When nothing older remains buffered,
        // the head is the word being pushed right now, which lets a stream
        // word reach the bus one cycle after its handshake.
        head_ptr_s = rd_ptr_r + PTR_WIDTH'(accept_s);
        if (count_r == CNT_WIDTH'(accept_s)) begin
            head_data_s = bus.stream_data_i;
            head_be_s   = bus.stream_be_i;
        end else begin
            head_data_s = fifo_data_r[head_ptr_s];
            head_be_s   = fifo_be_r[head_ptr_s];
        end
    end

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_next_s = (bus.ctrl_length_i == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (finish_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        base_next_s       = start_ok_s ? bus.ctrl_base_addr_i : base_r;
        length_next_s     = start_ok_s ? bus.ctrl_length_i : length_r;
        words_done_next_s = start_ok_s ? {LEN_WIDTH{1'b0}} : (words_done_r + LEN_WIDTH'(accept_s));
        words_in_next_s   = start_ok_s ? {LEN_WIDTH{1'b0}} : (words_in_r + LEN_WIDTH'(push_s));

        count_next_s  = flush_s ? {CNT_WIDTH{1'b0}} : avail_s;
        wr_ptr_next_s = flush_s ? {PTR_WIDTH{1'b0}} : (wr_ptr_r + PTR_WIDTH'(push_s));
        rd_ptr_next_s = flush_s ? {PTR_WIDTH{1'b0}} : (rd_ptr_r + PTR_WIDTH'(accept_s));

        // An abort seen while a write is stalled is remembered until that
        // write is accepted; the write itself is never withdrawn.
        abort_pend_next_s = (state_next_s == ST_RUN) && stop_s;

        if (issue_s) begin
            write_next_s      = 1'b1;
            address_next_s    = base_r + words_done_next_s[ADDR_WIDTH-1:0];
            writedata_next_s  = head_data_s;
            byteenable_next_s = head_be_s;
        end else begin
            write_next_s      = accept_s ? 1'b0 : write_r;
            address_next_s    = address_r;
            writedata_next_s  = writedata_r;
            byteenable_next_s = byteenable_r;
        end

        ready_next_s = (state_next_s == ST_RUN) && (count_next_s < FIFO_FULL) &&
                       (words_in_next_s < length_next_s) && !abort_pend_next_s;
        busy_next_s  = (state_next_s == ST_RUN);
        done_next_s  = (state_next_s == ST_DONE);

        if (start_ok_s) begin
            error_next_s = 1'b0;
        end else if (bus.ctrl_start_i) begin
            error_next_s = 1'b1;
        end else begin
            error_next_s = error_r;
        end
    end

    // State, counter, Avalon request and status registers.
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            state_r      <= ST_IDLE;
            base_r       <= {ADDR_WIDTH{1'b0}};
            length_r     <= {LEN_WIDTH{1'b0}};
            words_done_r <= {LEN_WIDTH{1'b0}};
            words_in_r   <= {LEN_WIDTH{1'b0}};
            abort_pend_r <= 1'b0;
            wr_ptr_r     <= {PTR_WIDTH{1'b0}};
            rd_ptr_r     <= {PTR_WIDTH{1'b0}};
            count_r      <= {CNT_WIDTH{1'b0}};
            write_r      <= 1'b0;
            address_r    <= {ADDR_WIDTH{1'b0}};
            writedata_r  <= {DATA_WIDTH{1'b0}};
            byteenable_r <= {BE_WIDTH{1'b0}};
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            base_r       <= base_next_s;
            length_r     <= length_next_s;
            words_done_r <= words_done_next_s;
            words_in_r   <= words_in_next_s;
            abort_pend_r <= abort_pend_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            write_r      <= write_next_s;
            address_r    <= address_next_s;
            writedata_r  <= writedata_next_s;
            byteenable_r <= byteenable_next_s;
            ready_r      <= ready_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
            error_r      <= error_next_s;
        end
    end

    // FIFO storage; a word pushed in the cycle the transfer ends is dropped.
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
                fifo_be_r[i]   <= {BE_WIDTH{1'b0}};
            end
        end else if (push_s && !flush_s) begin
            fifo_data_r[wr_ptr_r] <= bus.stream_data_i;
            fifo_be_r[wr_ptr_r]   <= bus.stream_be_i;
        end
    end

    assign bus.stream_ready_o   = ready_r;
    assign bus.avm_address_o    = address_r;
    assign bus.avm_write_o      = write_r;
    assign bus.avm_writedata_o  = writedata_r;
    assign bus.avm_byteenable_o = byteenable_r;
    assign bus.status_busy_o    = busy_r;
    assign bus.status_done_o    = done_r;
    assign bus.status_words_o   = words_done_r;
    assign bus.status_error_o   = error_r;

endmodule

// File: tb/tb_comm_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_comm_buffer_writer
//
// Scoreboard bench for comm_buffer_writer. Each transfer generates its stream
// words up front; the expected Avalon writes ((base+i) mod 4096, word i) and
// the expected end-of-transfer word count are queued. Independent processes
// drive the stream, drive waitrequest, and monitor the bus, popping and
// comparing on every accepted write and every done pulse.
// -----------------------------------------------------------------------------
module tb_comm_buffer_writer;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int LW = 13;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    be;
    } wr_t;

    typedef struct {
        int words;
        bit chk_lat;
    } done_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    be;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comm_buffer_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    comm_buffer_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(2)
    ) dut (
        .clock_sink_clk   (clk),
        .reset_sink_reset (rst),
        .bus              (bus)
    );

    wr_t   exp_q[$];
    done_t done_q[$];
    word_t feed_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_count = 0;
    int hs_count  = 0;
    int done_seen = 0;
    int first_acc_cyc = 0;
    int last_acc_cyc  = 0;
    int hold_cnt  = 0;
    int exp_hold  = 0;
    int stall_idx = -1;
    int stall_left = 0;
    bit wr_mode    = 1'b0;
    bit valid_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // waitrequest driver: directed stall on one write index, else random or 0
    initial begin
        bus.avm_waitrequest_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && bus.avm_write_o && acc_count == stall_idx) begin
                bus.avm_waitrequest_i = 1'b1;
                stall_left--;
            end else if (wr_mode) begin
                bus.avm_waitrequest_i = ($urandom_range(0, 3) == 0);
            end else begin
                bus.avm_waitrequest_i = 1'b0;
            end
        end
    end

    // stream source: offers feed_q words in order
    initial begin
        bit hs;
        bus.stream_valid_i = 1'b0;
        bus.stream_data_i  = '0;
        bus.stream_be_i    = '0;
        forever begin
            @(negedge clk);
            hs = bus.stream_valid_i && bus.stream_ready_o && !rst;
            @(posedge clk); #1;
            if (hs && feed_q.size() > 0) begin
                void'(feed_q.pop_front());
                hs_count++;
            end
            if (feed_q.size() > 0 && (!valid_mode || $urandom_range(0, 2) != 0)) begin
                bus.stream_valid_i = 1'b1;
                bus.stream_data_i  = feed_q[0].data;
                bus.stream_be_i    = feed_q[0].be;
            end else begin
                bus.stream_valid_i = 1'b0;
            end
        end
    end

    // monitor: compares accepted writes and done pulses against the queues
    initial begin
        bit            prev_stall = 1'b0;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_data;
        logic [7:0]    s_be;
        wr_t           e;
        done_t         d;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_write_held", bus.avm_write_o, 1);
                    chk("stall_addr_held", bus.avm_address_o, s_addr);
                    chk("stall_data_held", bus.avm_writedata_o, s_data);
                    chk("stall_be_held", bus.avm_byteenable_o, s_be);
                end
                prev_stall = bus.avm_write_o && bus.avm_waitrequest_i;
                s_addr = bus.avm_address_o;
                s_data = bus.avm_writedata_o;
                s_be   = bus.avm_byteenable_o;
                if (bus.avm_write_o) hold_cnt++;
                if (bus.avm_write_o && !bus.avm_waitrequest_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_write: got write at 0x%0h, required none", bus.avm_address_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", bus.avm_address_o, e.addr);
                        chk("write_data", bus.avm_writedata_o, e.data);
                        chk("write_be", bus.avm_byteenable_o, e.be);
                    end
                    if (acc_count == 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                    if (exp_hold > 0 && acc_count == stall_idx) chk("stall_hold_cycles", hold_cnt, exp_hold);
                    acc_count++;
                    hold_cnt = 0;
                end
                if (bus.status_done_o) begin
                    done_seen++;
                    chk("busy_low_at_done", bus.status_busy_o, 0);
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_done: got done pulse, required none");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_words", bus.status_words_o, d.words);
                        if (d.chk_lat) chk("done_after_last_accept", cyc - last_acc_cyc, 1);
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic [AW-1:0] base, input int len, input bit wrm, input bit vm,
                            input int sidx, input int scyc, input int ehold,
                            input bit abort_it, input bit poke);
        int    n_exp;
        int    t;
        int    d0;
        int    start_cyc;
        word_t w;
        wr_t   e;
        n_exp = abort_it ? sidx + 1 : len;
        wr_mode = wrm; valid_mode = vm; stall_idx = sidx; stall_left = scyc;
        exp_hold = ehold; acc_count = 0; hs_count = 0; hold_cnt = 0;
        for (int i = 0; i < len; i++) begin
            w.data = {$urandom, $urandom};
            w.be   = 8'($urandom);
            feed_q.push_back(w);
            if (i < n_exp) begin
                e.addr = base + AW'(i);
                e.data = w.data;
                e.be   = w.be;
                exp_q.push_back(e);
            end
        end
        done_q.push_back('{n_exp, (len > 0)});
        d0 = done_seen;
        bus.ctrl_base_addr_i = base;
        bus.ctrl_length_i    = LW'(len);
        bus.ctrl_start_i     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.ctrl_start_i = 1'b0;
        chk("error_clear_on_start", bus.status_error_o, 0);
        if (len > 0) chk("busy_after_start", bus.status_busy_o, 1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            if (bus.status_busy_o) begin
                bus.ctrl_base_addr_i = AW'($urandom);
                bus.ctrl_length_i    = LW'($urandom_range(1, 50));
                bus.ctrl_start_i     = 1'b1;
                @(posedge clk); #1;
                bus.ctrl_start_i = 1'b0;
                chk("error_set_on_busy_start", bus.status_error_o, 1);
            end
        end
        if (abort_it || ehold > 0) begin
            t = 0;
            do begin
                @(negedge clk); #1;
                t++;
            end while (!(acc_count == sidx && bus.avm_write_o && bus.avm_waitrequest_i) && t < 200);
            chk("stall_reached", (t < 200), 1);
            if (ehold > 0) begin
                @(negedge clk);
                chk("ready_low_when_fifo_full", bus.stream_ready_o, 0);
            end
            if (abort_it) begin
                @(posedge clk); #1;
                bus.ctrl_abort_i = 1'b1;
                @(posedge clk); #1;
                bus.ctrl_abort_i = 1'b0;
            end
        end
        t = 0;
        while (done_seen == d0 && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("done_seen", (done_seen != d0), 1);
        if (len == 0) begin
            chk("len0_done_latency", ((cyc - start_cyc) >= 1 && (cyc - start_cyc) <= 2), 1);
            chk("len0_no_writes", acc_count, 0);
        end
        if (!abort_it) chk("stream_words_taken", hs_count, len);
        chk("expected_writes_drained", exp_q.size(), 0);
        feed_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ctrl_start_i     = 1'b0;
        bus.ctrl_abort_i     = 1'b0;
        bus.ctrl_base_addr_i = '0;
        bus.ctrl_length_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_write", bus.avm_write_o, 0);
        chk("reset_ready", bus.stream_ready_o, 0);
        chk("reset_busy", bus.status_busy_o, 0);
        chk("reset_words", bus.status_words_o, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic 3-word transfer, no stalls: back-to-back writes
        run_xfer(12'h010, 3, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        chk("consecutive_writes", last_acc_cyc - first_acc_cyc, 2);
        // second write stalled 4 cycles: held 5 cycles, ready drops
        run_xfer(12'h010, 6, 1'b0, 1'b0, 1, 4, 5, 1'b0, 1'b0);
        // address wrap
        run_xfer(12'hFFE, 4, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        // zero length
        run_xfer(12'h123, 0, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        // abort during stalled second write of 8
        run_xfer(12'h200, 8, 1'b0, 1'b0, 1, 6, 0, 1'b1, 1'b0);
        // start while busy, then a fresh start clears the error
        run_xfer(12'h300, 8, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b1);
        run_xfer(12'h400, 2, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        // randomized transfers
        for (int k = 0; k < 15; k++) begin
            run_xfer(AW'($urandom), $urandom_range(1, 20), 1'b1, 1'b1, -1, 0, 0, 1'b0, 1'b0);
        end

        // reset in the middle of a transfer
        for (int i = 0; i < 10; i++) feed_q.push_back('{{$urandom, $urandom}, 8'hFF});
        bus.ctrl_base_addr_i = 12'h500;
        bus.ctrl_length_i    = 13'd10;
        bus.ctrl_start_i     = 1'b1;
        wr_mode = 1'b0; valid_mode = 1'b0; stall_left = 0; stall_idx = -1;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back('{12'h500 + AW'(i), feed_q[i].data, 8'hFF});
        @(posedge clk); #1;
        bus.ctrl_start_i = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_start_i = 1'b0;
        chk("error_before_reset", bus.status_error_o, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset_write", bus.avm_write_o, 0);
        chk("async_reset_addr", bus.avm_address_o, 0);
        chk("async_reset_data", bus.avm_writedata_o, 0);
        chk("async_reset_ready", bus.stream_ready_o, 0);
        chk("async_reset_busy", bus.status_busy_o, 0);
        chk("async_reset_words", bus.status_words_o, 0);
        chk("async_reset_error", bus.status_error_o, 0);
        exp_q.delete();
        done_q.delete();
        feed_q.delete();
        hold_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_xfer(12'h0F0, 5, 1'b1, 1'b1, -1, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
